// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU load/store stage and an
// auxiliary master, round-robin on conflict, with read-return tracking and a stall counter.
module dmem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic [3:0]        aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [31:0]       aux_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_AUX = 1'b1
    } gnt_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_AUX  = 2'd2
    } rd_owner_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    gnt_e              last_gnt_reg;
    rd_owner_e         rd_owner_reg;
    rd_owner_e         rd_owner_next;
    logic [31:0]       cpu_rdata_reg;
    logic              aux_rvalid_reg;
    logic [31:0]       aux_rdata_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [31:0]       din_hold_reg;

    logic              cpu_granted;
    logic              aux_granted;
    logic              any_granted;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    // Grant decision depends only on the request lines and last_gnt, never on RAM data.
    always_comb begin
        cpu_granted = 1'b0;
        aux_granted = 1'b0;
        if (cpu_req && aux_req) begin
            cpu_granted = (last_gnt_reg == GNT_AUX);
            aux_granted = (last_gnt_reg == GNT_CPU);
        end else begin
            cpu_granted = cpu_req;
            aux_granted = aux_req;
        end
    end

    assign any_granted = cpu_granted | aux_granted;
    assign cpu_stall   = cpu_req & ~cpu_granted;
    assign aux_gnt     = aux_req & aux_granted;
    assign ram_en      = any_granted;

    assign sel_addr  = cpu_granted ? cpu_addr  : aux_addr;
    assign sel_wdata = cpu_granted ? cpu_wdata : aux_wdata;
    assign ram_addr  = any_granted ? sel_addr  : addr_hold_reg;

    // Byte lanes: write strobes are suppressed during reset so a colliding write is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_we[gi] = ~rst & ((cpu_granted & cpu_we[gi]) | (aux_granted & aux_we[gi]));
            assign ram_din[gi*8 +: 8] = any_granted ? sel_wdata[gi*8 +: 8] : din_hold_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rd_owner_next = RD_NONE;
        if (cpu_granted && (cpu_we == 4'd0)) begin
            rd_owner_next = RD_CPU;
        end else if (aux_granted && (aux_we == 4'd0)) begin
            rd_owner_next = RD_AUX;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_cnt_clr) begin
            stall_cnt_next = '0;
        end else if (cpu_stall && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg   <= GNT_AUX;
            rd_owner_reg   <= RD_NONE;
            cpu_rdata_reg  <= '0;
            aux_rvalid_reg <= 1'b0;
            aux_rdata_reg  <= '0;
            stall_cnt_reg  <= '0;
            addr_hold_reg  <= '0;
            din_hold_reg   <= '0;
        end else begin
            if (cpu_granted) begin
                last_gnt_reg <= GNT_CPU;
            end else if (aux_granted) begin
                last_gnt_reg <= GNT_AUX;
            end
            if (any_granted) begin
                addr_hold_reg <= sel_addr;
                din_hold_reg  <= sel_wdata;
            end
            rd_owner_reg   <= rd_owner_next;
            // ram_dout now holds the word addressed in the previous grant cycle.
            aux_rvalid_reg <= (rd_owner_reg == RD_AUX);
            if (rd_owner_reg == RD_CPU) begin
                cpu_rdata_reg <= ram_dout;
            end
            if (rd_owner_reg == RD_AUX) begin
                aux_rdata_reg <= ram_dout;
            end
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign cpu_rdata  = cpu_rdata_reg;
    assign aux_rvalid = aux_rvalid_reg;
    assign aux_rdata  = aux_rdata_reg;
    assign stall_cnt  = stall_cnt_reg;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data block RAM between two requesters: the CPU datapath (stage-2 load/store) and an auxiliary master (UART loader / debug DMA).
- Grants one access per cycle with round-robin priority on conflict.
- Drives the CPU's `stall` when the CPU loses arbitration.
- Holds read data for each requester and counts contention-stall cycles for performance monitoring.

Parameters:
- ADDR_W, 12, word-address width of the RAM port.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_we  in  4  CPU byte write enables; 0 means read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data, already lane-shifted
- cpu_rdata  out  32  CPU read data, held
- cpu_stall  out  1  CPU lost arbitration this cycle; freeze pipeline
- aux_req  in  1  aux requests an access
- aux_we  in  4  aux byte write enables; 0 means read
- aux_addr  in  ADDR_W  aux word address
- aux_wdata  in  32  aux write data
- aux_gnt  out  1  aux access accepted this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  32  aux read data
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data; synchronous, 1-cycle latency
- stall_cnt  out  CNT_W  cycles in which cpu_stall was 1, saturating
- stall_cnt_clr  in  1  clears stall_cnt

Behaviour:
- Clock and reset: single clock `clk`, synchronous active-high reset `rst`.
- Reset values: last_gnt=AUX (so the CPU wins the first conflict), cpu_rdata=0, aux_rvalid=0, aux_rdata=0, stall_cnt=0, internal rd_owner=NONE.
- Grant logic (combinational, same cycle):
  - Only cpu_req: grant CPU.
  - Only aux_req: grant AUX.
  - Both: grant the requester that is not last_gnt.
  - Neither: no grant; ram_en=0, ram_we=0.
- Outputs of the grant:
  - cpu_stall = cpu_req & ~cpu_granted.
  - aux_gnt = aux_req & aux_granted.
- RAM mux: the granted requester's we/addr/wdata drive ram_we/ram_addr/ram_din, and ram_en=1. With no grant, ram_addr/ram_din hold their last value (don't-care) and ram_we=0.
- last_gnt: updates on every cycle with a grant; holds otherwise.
- Read tracking:
  - Register rd_owner = {CPU, AUX, NONE}, set on a granted access with we==0, else NONE.
  - Next cycle, if rd_owner=CPU: cpu_rdata <= ram_dout, registered so it stays held until the next CPU read completes.
  - Next cycle, if rd_owner=AUX: aux_rdata captured, aux_rvalid=1 for exactly that one cycle.
  - Read latency: data is visible 2 edges after the grant cycle for both requesters (RAM edge plus capture edge).
- Writes:
  - Produce no rvalid and do not disturb cpu_rdata or aux_rdata.
  - Partial byte writes pass through unchanged.
- CPU retry: a stalled CPU re-presents the same request next cycle; round-robin guarantees it wins by then.
- Aux retry: aux must hold req/we/addr/wdata stable until aux_gnt; it may drop req after the granted cycle.
- Sustained contention: grants alternate C,A,C,A…; each requester is worst-case stalled 1 cycle.
- stall_cnt:
  - Increments each cycle cpu_stall=1.
  - Saturates at 2^CNT_W−1 with no wrap.
  - stall_cnt_clr forces 0 and has priority over increment.
- Reset mid-operation: a pending read capture is dropped (no aux_rvalid), rd_owner=NONE, and a write issued in the reset cycle is not performed (ram_we forced 0 while rst=1).
- Timing: the cpu_stall path is combinational from cpu_req/aux_req, with no dependence on ram_dout.

Test Plan:
- CPU-only read: after preloading RAM[0x010]=0xDEADBEEF, CPU reads 0x010 → cpu_stall=0, ram_en=1 in the same cycle, and cpu_rdata=0xDEADBEEF after the 2nd edge; it stays held while the CPU writes 0x011.
- Aux write then read: aux writes 0xA5A5_0F0F to 0x3FF with we=0xF, then reads 0x3FF → aux_gnt=1 on each, and aux_rvalid=1 for exactly 1 cycle with aux_rdata=0xA5A50F0F; aux_rvalid stays 0 for the write.
- First conflict after reset: both request in cycle 0 → CPU granted, cpu_stall=0, aux_gnt=0; cycle 1, both still requesting → aux granted, cpu_stall=1, stall_cnt=1 after that cycle.
- Sustained conflict for 6 cycles: grant sequence C,A,C,A,C,A; cpu_stall pattern 0,1,0,1,0,1; stall_cnt=3; no request is lost (RAM write log matches).
- Saturation/clear with CNT_W=2: hold conflict for 10 cycles → stall_cnt stops at 3; pulse stall_cnt_clr coincident with a stall cycle → 0 next cycle.
- Reset mid-read: aux read granted, rst=1 on the next edge → aux_rvalid never asserts, last_gnt=AUX, and the following conflict grants the CPU first.
